// File: rtl/fifo_credit_push_ctrl.sv
// Credit-based push controller guarding a one-in-one-out FIFO that overwrites on overflow.
// Latency 1 (accept -> push_vld); backpressure via src_rdy = credits available & RUN state.
// Optional sticky credit-overflow flag under macro FIFO_CRD_OVF_CHK_EN.
module fifo_credit_push_ctrl #(
    parameter int ENT_NUM   = 4,
    parameter int DATA_SIZE = 32,
    parameter int CRD_WIDTH = $clog2(ENT_NUM + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 src_vld,
    input  logic [DATA_SIZE-1:0] src_data,
    output logic                 src_rdy,
    output logic                 push_vld,
    output logic [DATA_SIZE-1:0] push_data,
    input  logic                 crd_ret,
    input  logic                 flush_req,
    output logic                 flush_ack,
`ifdef FIFO_CRD_OVF_CHK_EN
    output logic                 err_crd_ovf,
`endif
    output logic [CRD_WIDTH-1:0] crd_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        FLUSH_WAIT = 2'd1,
        FLUSH_DONE = 2'd2
    } state_t;

    localparam logic [CRD_WIDTH-1:0] CRD_MAX = CRD_WIDTH'(ENT_NUM);
    localparam logic [CRD_WIDTH-1:0] CRD_ONE = CRD_WIDTH'(1);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   crd_full;

    // Ready depends on registered state only, never on src_vld.
    assign src_rdy   = (crd_cnt != '0) && (state == RUN);
    assign accept    = src_vld & src_rdy;
    assign crd_full  = (crd_cnt == CRD_MAX);
    assign flush_ack = (state == FLUSH_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crd_cnt <= CRD_MAX;
        end else if (accept && !crd_ret) begin
            crd_cnt <= crd_cnt - CRD_ONE;
        end else if (crd_ret && !accept && !crd_full) begin
            crd_cnt <= crd_cnt + CRD_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            push_vld  <= 1'b0;
            push_data <= '0;
        end else begin
            push_vld <= accept;
            if (accept) begin
                push_data <= src_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Drain is complete only once every credit is back and nothing is still in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:        if (flush_req) state_nxt = FLUSH_WAIT;
            FLUSH_WAIT: if (crd_full && !push_vld) state_nxt = FLUSH_DONE;
            FLUSH_DONE: state_nxt = RUN;
            default:    state_nxt = RUN;
        endcase
    end

`ifdef FIFO_CRD_OVF_CHK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_crd_ovf <= 1'b0;
        end else if (crd_ret && !accept && crd_full) begin
            err_crd_ovf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_credit_push_ctrl.sv
// Randomized plus directed bench for fifo_credit_push_ctrl against an occupancy-based reference model.
module tb_fifo_credit_push_ctrl;

    localparam int ENT_NUM   = 4;
    localparam int DATA_SIZE = 32;
    localparam int CRD_WIDTH = $clog2(ENT_NUM + 1);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 src_vld;
    logic [DATA_SIZE-1:0] src_data;
    logic                 src_rdy;
    logic                 push_vld;
    logic [DATA_SIZE-1:0] push_data;
    logic                 crd_ret;
    logic                 flush_req;
    logic                 flush_ack;
    logic [CRD_WIDTH-1:0] crd_cnt;
`ifdef FIFO_CRD_OVF_CHK_EN
    logic                 err_crd_ovf;
`endif

    fifo_credit_push_ctrl #(
        .ENT_NUM(ENT_NUM), .DATA_SIZE(DATA_SIZE), .CRD_WIDTH(CRD_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_vld(src_vld), .src_data(src_data), .src_rdy(src_rdy),
        .push_vld(push_vld), .push_data(push_data),
        .crd_ret(crd_ret), .flush_req(flush_req), .flush_ack(flush_ack),
`ifdef FIFO_CRD_OVF_CHK_EN
        .err_crd_ovf(err_crd_ovf),
`endif
        .crd_cnt(crd_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: items outstanding (pushed but not returned), flush phase, last push.
    localparam int M_RUN = 0, M_WAIT = 1, M_DONE = 2;
    int                   m_out;
    int                   m_mode;
    logic                 m_pv;
    logic [DATA_SIZE-1:0] m_pd;
    logic                 m_ovf;
    int                   n_acc;
    int                   n_ack;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out  = 0;
        m_mode = M_RUN;
        m_pv   = 1'b0;
        m_pd   = '0;
        m_ovf  = 1'b0;
    endtask

    function automatic int fifo_fill();
        return m_out - int'(m_pv);
    endfunction

    // Check outputs mid-cycle, then advance the model by the rules for the coming edge.
    task automatic cycle();
        logic rdy, acc;
        int   nout;
        @(negedge clk);
        rdy = (m_out < ENT_NUM) && (m_mode == M_RUN);
        acc = src_vld && rdy;
        chk("src_rdy",   64'(src_rdy),   64'(rdy));
        chk("push_vld",  64'(push_vld),  64'(m_pv));
        chk("push_data", 64'(push_data), 64'(m_pd));
        chk("crd_cnt",   64'(crd_cnt),   64'(ENT_NUM - m_out));
        chk("flush_ack", 64'(flush_ack), 64'(m_mode == M_DONE));
`ifdef FIFO_CRD_OVF_CHK_EN
        chk("err_crd_ovf", 64'(err_crd_ovf), 64'(m_ovf));
`endif
        if (m_mode == M_DONE) n_ack++;
        nout = m_out + int'(acc) - int'(crd_ret);
        if (nout < 0) begin
            nout  = 0;
            m_ovf = 1'b1;
        end
        case (m_mode)
            M_RUN:   m_mode = flush_req ? M_WAIT : M_RUN;
            M_WAIT:  m_mode = (m_out == 0 && !m_pv) ? M_DONE : M_WAIT;
            default: m_mode = M_RUN;
        endcase
        m_out = nout;
        m_pv  = acc;
        if (acc) begin
            m_pd = src_data;
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        src_vld   = 1'b0;
        flush_req = 1'b0;
        for (int k = 0; k < 40 && m_out != 0; k++) begin
            crd_ret = (fifo_fill() > 0);
            cycle();
        end
        crd_ret = 1'b0;
        chk("drain_empty", 64'(crd_cnt), 64'(ENT_NUM));
    endtask

    initial begin
        int fr_left;
        int seen;
        rst_n = 1'b0; src_vld = 1'b1; src_data = 32'hA0; crd_ret = 1'b0; flush_req = 1'b0;
        n_acc = 0; n_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_crd_cnt",   64'(crd_cnt),   64'(ENT_NUM));
        chk("rst_push_vld",  64'(push_vld),  64'd0);
        chk("rst_push_data", 64'(push_data), 64'd0);
        chk("rst_flush_ack", 64'(flush_ack), 64'd0);
        rst_n = 1'b1;

        // Fill from reset: A0..A3 pushed back to back, then stalled.
        for (int k = 0; k < 7; k++) begin
            src_data = 32'hA0 + 32'(n_acc);
            cycle();
        end
        chk("fill_crd0",   64'(crd_cnt),   64'd0);
        chk("fill_stall",  64'(src_rdy),   64'd0);
        chk("fill_last",   64'(push_data), 64'hA3);

        // One credit back lets exactly A4 through.
        crd_ret = 1'b1;
        cycle();
        crd_ret = 1'b0;
        for (int k = 0; k < 3; k++) begin
            src_data = 32'hA0 + 32'(n_acc);
            cycle();
        end
        chk("one_crd_data", 64'(push_data), 64'hA4);
        chk("one_crd_cnt",  64'(crd_cnt),   64'd0);
        drain();

        // Accept and return in the same cycle at crd_cnt==2.
        src_vld = 1'b1;
        for (int k = 0; k < 10 && m_out < 2; k++) begin
            src_data = $urandom;
            cycle();
        end
        chk("pre_both_cnt", 64'(crd_cnt), 64'd2);
        src_data = 32'h5A5A_0036;
        crd_ret  = 1'b1;
        cycle();
        src_vld = 1'b0; crd_ret = 1'b0;
        chk("both_cnt",  64'(crd_cnt),  64'd2);
        chk("both_push", 64'(push_vld), 64'd1);
        drain();

        // Flush with three items outstanding.
        src_vld = 1'b1;
        for (int k = 0; k < 10 && m_out < 3; k++) begin
            src_data = $urandom;
            cycle();
        end
        src_vld = 1'b0;
        flush_req = 1'b1;
        cycle();
        chk("flush_block", 64'(src_rdy), 64'd0);
        seen = 0;
        for (int k = 0; k < 30 && seen == 0; k++) begin
            crd_ret = (fifo_fill() > 0);
            if (k > 1) flush_req = 1'b0;
            if (flush_ack) seen = 1;
            cycle();
        end
        crd_ret = 1'b0;
        chk("flush_ack_seen", 64'(seen), 64'd1);
        chk("flush_crd_full", 64'(crd_cnt), 64'(ENT_NUM));
        chk("flush_ack_drop", 64'(flush_ack), 64'd0);
        chk("flush_back_run", 64'(src_rdy), 64'd1);

        // Return at full credits saturates.
        crd_ret = 1'b1;
        cycle();
        crd_ret = 1'b0;
        cycle();
        chk("sat_cnt", 64'(crd_cnt), 64'(ENT_NUM));
`ifdef FIFO_CRD_OVF_CHK_EN
        chk("ovf_sticky", 64'(err_crd_ovf), 64'd1);
`endif

        // Random traffic with occasional flush requests.
        fr_left = 0;
        for (int k = 0; k < 400; k++) begin
            src_vld  = ($urandom_range(0, 3) != 0);
            src_data = $urandom;
            crd_ret  = (fifo_fill() > 0) && ($urandom_range(0, 2) != 0);
            if (fr_left == 0 && $urandom_range(0, 29) == 0) fr_left = $urandom_range(1, 5);
            flush_req = (fr_left > 0);
            if (fr_left > 0) fr_left--;
            cycle();
        end
        drain();
        chk("rand_acks", 64'(n_ack > 0), 64'd1);

        // Reset in the middle of a flush while a push is in flight.
        src_vld = 1'b1; src_data = 32'hDEAD_BEEF; flush_req = 1'b1;
        for (int k = 0; k < 5 && m_mode == M_RUN; k++) cycle();
        chk("mid_push", 64'(push_vld), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_push_vld",  64'(push_vld),  64'd0);
        chk("mrst_push_data", 64'(push_data), 64'd0);
        chk("mrst_crd_cnt",   64'(crd_cnt),   64'(ENT_NUM));
        chk("mrst_flush_ack", 64'(flush_ack), 64'd0);
`ifdef FIFO_CRD_OVF_CHK_EN
        chk("mrst_ovf", 64'(err_crd_ovf), 64'd0);
`endif
        src_vld = 1'b0; flush_req = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
